// File: rtl/mem_interface.sv
// MAR/MDR memory-access stage between the Mini SRC bus and a synchronous 512x32 RAM.
// Define MEM_ADDR_CHECK_EN to fault requests whose MAR has bits set above the RAM address range.
module mem_interface #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] mdr_out,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              addr_err
);

`ifdef MEM_ADDR_CHECK_EN
    localparam int MAR_W = DATA_W;
`else
    localparam int MAR_W = ADDR_W;
`endif

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_CAPT,
        WR_ISSUE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [MAR_W-1:0]  mar;
    logic [MAR_W-1:0]  mar_next;
    logic [DATA_W-1:0] mdr;
    logic              idle;
    logic              request;
    logic              fault;

    assign idle    = (state == IDLE);
    assign request = idle && (mem_read || mem_write);

    // A request accompanied by mar_in must see the address being loaded on the same edge.
    assign mar_next = (idle && mar_in) ? bus_in[MAR_W-1:0] : mar;

`ifdef MEM_ADDR_CHECK_EN
    assign fault = |mar_next[MAR_W-1:ADDR_W];
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        busy       = 1'b1;
        ram_read   = 1'b0;
        ram_write  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (request) begin
                    if (fault) begin
                        state_next = DONE;
                    end else if (mem_write) begin
                        state_next = WR_ISSUE;
                    end else begin
                        state_next = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                ram_read   = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT:  state_next = RD_CAPT;
            RD_CAPT:  state_next = DONE;
            WR_ISSUE: begin
                ram_write  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            mar <= '0;
        end else begin
            mar <= mar_next;
        end
    end

    // Read data lands in MDR one cycle after the RAM's registered output becomes valid.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            mdr <= '0;
        end else if (state == RD_CAPT) begin
            mdr <= ram_data_out;
        end else if (idle && mdr_in) begin
            mdr <= bus_in;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    logic addr_err_q;

    // The flag reflects the most recently accepted request and persists until the next one.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            addr_err_q <= 1'b0;
        end else if (request) begin
            addr_err_q <= fault;
        end
    end

    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

    assign mdr_out     = mdr;
    assign ram_data_in = mdr;
    assign ram_address = mar[ADDR_W-1:0];

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: vector table, hand-written reset/busy/back-to-back sequences,
// and randomized requests checked against a transaction-level model with its own memory image.
module tb_mem_interface;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic              clock;
    logic              clear;
    logic [DATA_W-1:0] bus_in;
    logic              mar_in;
    logic              mdr_in;
    logic              mem_read;
    logic              mem_write;
    logic              done;
    logic              busy;
    logic [DATA_W-1:0] mdr_out;
    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out = '0;
    logic              addr_err;

    mem_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock       (clock),
        .clear       (clear),
        .bus_in      (bus_in),
        .mar_in      (mar_in),
        .mdr_in      (mdr_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .done        (done),
        .busy        (busy),
        .mdr_out     (mdr_out),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_address (ram_address),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out),
        .addr_err    (addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_val(input logic [8:0] a);
        if (a == 9'h095) return 32'h000000FF;
        return ({23'd0, a} * 32'h00010003) ^ 32'hA5A50000;
    endfunction

    // Synchronous RAM with registered read; contents preloaded on its first clock.
    logic [31:0] tb_mem [512];
    logic        ram_ready = 1'b0;
    always @(posedge clock) begin
        if (!ram_ready) begin
            for (int i = 0; i < 512; i++) tb_mem[i] <= init_val(9'(i));
            ram_ready <= 1'b1;
        end else begin
            if (ram_write) tb_mem[ram_address] <= ram_data_in;
            if (ram_read) ram_data_out <= tb_mem[ram_address];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [512];
    logic [31:0] m_mar;
    logic [31:0] m_mdr;
    logic        m_err;
    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        logic        ld_mar;
        logic        ld_mdr;
        logic [31:0] bus;
        logic        rd;
        logic        wr;
        int          len;
        logic [31:0] mdr;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_in    = '0;
    endtask

    task automatic model_reset();
        m_mar = '0;
        m_mdr = '0;
        m_err = 1'b0;
    endtask

    // Expected outcome of one request from the model's state, using the stage's rules.
    task automatic predict(input logic ld_mar, input logic ld_mdr, input logic [31:0] bus,
                           input logic rd, input logic wr,
                           output int len, output logic [31:0] exp_mdr, output logic exp_err);
        logic [31:0] a;
        logic [31:0] d;
        logic        bad;
        a = ld_mar ? bus : m_mar;
        d = ld_mdr ? bus : m_mdr;
`ifdef MEM_ADDR_CHECK_EN
        bad = (a[31:9] != 23'd0);
`else
        bad = 1'b0;
`endif
        exp_mdr = d;
        exp_err = m_err;
        len     = 0;
        if (rd || wr) begin
            exp_err = bad;
            if (bad) len = 1;
            else if (wr) len = 2;
            else begin
                len     = 4;
                exp_mdr = ref_mem[a[8:0]];
            end
        end
    endtask

    // Called at a negedge with the DUT idle; drives one request and checks every cycle until idle again.
    task automatic run_req(input logic ld_mar, input logic ld_mdr, input logic [31:0] bus,
                           input logic rd, input logic wr, input int len,
                           input logic [31:0] exp_mdr, input logic exp_err, input string tag);
        logic [31:0] a;
        logic [31:0] d;
        a = ld_mar ? bus : m_mar;
        d = ld_mdr ? bus : m_mdr;
        mar_in    = ld_mar;
        mdr_in    = ld_mdr;
        bus_in    = bus;
        mem_read  = rd;
        mem_write = wr;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clock);
            if (k <= len) begin
                chk({tag, " busy"}, busy, 1'b1);
                chk({tag, " done"}, done, k == len);
                chk({tag, " ram_read"}, ram_read, len == 4 && k == 1);
                chk({tag, " ram_write"}, ram_write, len == 2 && k == 1);
                if (k == 1 && (len == 4 || len == 2)) chk({tag, " ram_address"}, ram_address, a[8:0]);
                if (k == 1 && len == 2) chk({tag, " ram_data_in"}, ram_data_in, d);
                chk({tag, " mdr_out"}, mdr_out, (k == len) ? exp_mdr : d);
                chk({tag, " addr_err"}, addr_err, exp_err);
                // Requests and loads while busy must have no effect.
                mar_in    = 1'($urandom_range(0, 1));
                mdr_in    = 1'($urandom_range(0, 1));
                mem_read  = 1'($urandom_range(0, 1));
                mem_write = 1'($urandom_range(0, 1));
                bus_in    = $urandom;
            end else begin
                chk({tag, " idle busy"}, busy, 1'b0);
                chk({tag, " idle done"}, done, 1'b0);
                chk({tag, " idle strobes"}, {ram_read, ram_write}, 2'b00);
                chk({tag, " idle mdr_out"}, mdr_out, exp_mdr);
                chk({tag, " idle addr_err"}, addr_err, exp_err);
                zero_inputs();
            end
        end
        m_mar = a;
        m_mdr = exp_mdr;
        m_err = exp_err;
        if (len == 2) ref_mem[a[8:0]] = d;
    endtask

    initial begin
        clear = 1'b0;
        zero_inputs();
        model_reset();
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(9'(i));

        vecs[0] = '{1'b1, 1'b0, 32'h00000095, 1'b1, 1'b0, 4, 32'h000000FF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h000001F0, 1'b0, 1'b1, 2, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 0, 32'h00000000, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 4, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h000055AA, 1'b1, 1'b1, 2, 32'h000055AA, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 4, 32'h000055AA, 1'b0};
`ifdef MEM_ADDR_CHECK_EN
        vecs[7] = '{1'b1, 1'b0, 32'h00000200, 1'b1, 1'b0, 1, 32'h000055AA, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 32'h00000007, 1'b0, 1'b0, 0, 32'h00000007, 1'b1};
`else
        vecs[7] = '{1'b1, 1'b0, 32'h00000200, 1'b1, 1'b0, 4, 32'hA5A50000, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 32'h00000007, 1'b0, 1'b0, 0, 32'h00000007, 1'b0};
`endif
        vecs[9] = '{1'b1, 1'b0, 32'h00000095, 1'b1, 1'b0, 4, 32'h000000FF, 1'b0};

        repeat (3) @(negedge clock);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset strobes", {ram_read, ram_write}, 2'b00);
        chk("reset mdr_out", mdr_out, 32'h0);
        chk("reset ram_address", ram_address, 9'h0);
        chk("reset addr_err", addr_err, 1'b0);
        clear = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].ld_mar, vecs[i].ld_mdr, vecs[i].bus, vecs[i].rd, vecs[i].wr,
                    vecs[i].len, vecs[i].mdr, vecs[i].err, $sformatf("vec%0d", i));
        end

        // Loads attempted during RD_WAIT must not disturb MDR or MAR.
        run_req(1'b0, 1'b1, 32'hCAFE0001, 1'b0, 1'b0, 0, 32'hCAFE0001, 1'b0, "pre_busy");
        mem_read = 1'b1;
        @(negedge clock);
        zero_inputs();
        @(negedge clock);
        chk("busy_ign wait mdr", mdr_out, 32'hCAFE0001);
        mdr_in = 1'b1;
        mar_in = 1'b1;
        bus_in = 32'h12345678;
        @(negedge clock);
        chk("busy_ign capt mdr", mdr_out, 32'hCAFE0001);
        zero_inputs();
        @(negedge clock);
        chk("busy_ign done", done, 1'b1);
        chk("busy_ign mdr", mdr_out, 32'h000000FF);
        @(negedge clock);
        chk("busy_ign idle", busy, 1'b0);
        m_mdr = 32'h000000FF;

        // Back-to-back reads with mem_read held high.
        mem_read = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            chk($sformatf("b2b ram_read c%0d", k), ram_read, (k % 5) == 1);
            chk($sformatf("b2b done c%0d", k), done, (k % 5) == 4);
            chk($sformatf("b2b exclusive c%0d", k), ram_read & ram_write, 1'b0);
            if (k == 15) mem_read = 1'b0;
        end
        @(negedge clock);
        chk("b2b final busy", busy, 1'b0);
        chk("b2b final mdr", mdr_out, ref_mem[m_mar[8:0]]);
        m_mdr = ref_mem[m_mar[8:0]];

        // Reset while the read sits in RD_WAIT.
        mar_in   = 1'b1;
        bus_in   = 32'h00000095;
        mem_read = 1'b1;
        @(negedge clock);
        zero_inputs();
        chk("rst_rd issue", ram_read, 1'b1);
        @(negedge clock);
        chk("rst_rd wait strobe", ram_read, 1'b0);
        chk("rst_rd wait busy", busy, 1'b1);
        clear = 1'b0;
        #1;
        chk("rst_rd busy", busy, 1'b0);
        chk("rst_rd ram_read", ram_read, 1'b0);
        chk("rst_rd mdr", mdr_out, 32'h0);
        chk("rst_rd done", done, 1'b0);
        chk("rst_rd addr_err", addr_err, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("rst_rd held done", done, 1'b0);
            chk("rst_rd held busy", busy, 1'b0);
        end
        clear = 1'b1;
        model_reset();
        @(negedge clock);

        // Reset during WR_ISSUE, before its ending edge: the write must not land.
        run_req(1'b0, 1'b1, 32'h11112222, 1'b0, 1'b0, 0, 32'h11112222, 1'b0, "pre_wr");
        mar_in    = 1'b1;
        bus_in    = 32'h00000010;
        mem_write = 1'b1;
        @(negedge clock);
        zero_inputs();
        chk("rst_wr issue", ram_write, 1'b1);
        clear = 1'b0;
        #1;
        chk("rst_wr ram_write", ram_write, 1'b0);
        chk("rst_wr busy", busy, 1'b0);
        @(negedge clock);
        chk("rst_wr done", done, 1'b0);
        clear = 1'b1;
        model_reset();
        @(negedge clock);
        run_req(1'b1, 1'b0, 32'h00000010, 1'b1, 1'b0, 4, ref_mem[9'h010], 1'b0, "rst_wr readback");

        // Randomized requests against the model.
        for (int n = 0; n < 40; n++) begin
            logic        lm;
            logic        ld;
            logic        rd;
            logic        wr;
            logic [31:0] bus;
            int          op;
            int          len;
            logic [31:0] em;
            logic        ee;
            lm  = 1'($urandom_range(0, 1));
            ld  = 1'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 3));
            rd  = (op == 1) || (op == 3);
            wr  = (op == 2) || (op == 3);
            bus = ($urandom_range(0, 3) == 0) ? $urandom : {23'd0, 9'($urandom_range(0, 511))};
            predict(lm, ld, bus, rd, wr, len, em, ee);
            run_req(lm, ld, bus, rd, wr, len, em, ee, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- MAR/MDR memory-access stage between the Mini SRC datapath bus and the synchronous 512x32 RAM.
- Latches the address (MAR) and the data register (MDR) from the bus.
- Sequences RAM read/write strobes against the RAM's one-cycle registered read.
- Returns a single-cycle done pulse to the control unit; the control unit stalls until done.

Parameters:
- ADDR_W, 9, RAM address width (MAR low bits driven to RAM)
- DATA_W, 32, bus/RAM data width

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-low reset
- bus_in  in  DATA_W  datapath bus value
- mar_in  in  1  load MAR from bus_in
- mdr_in  in  1  load MDR from bus_in (ignored while busy)
- mem_read  in  1  start read request (sampled in IDLE only)
- mem_write  in  1  start write request (sampled in IDLE only)
- done  out  1  one-cycle completion pulse
- busy  out  1  high in any non-IDLE state
- mdr_out  out  DATA_W  current MDR contents to bus drivers
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_address  out  ADDR_W  MAR[ADDR_W-1:0]
- ram_data_in  out  DATA_W  write data to RAM (= MDR)
- ram_data_out  in  DATA_W  registered RAM read data
- addr_err  out  1  address fault flag (only with optional feature; tied 0 otherwise)

Behaviour:
- Reset (clear=0, async): MAR=0, MDR=0, state=IDLE, done=0, busy=0, ram_read=0, ram_write=0, addr_err=0.
- ram_address and ram_data_in are continuous from MAR/MDR.
- mar_in and mdr_in load on the rising edge; they are honoured in IDLE only.
- In IDLE, mar_in together with mem_read/mem_write: the request uses the newly loaded MAR, i.e. MAR loads and the request latches on the same edge.
- States: IDLE, RD_ISSUE, RD_WAIT, RD_CAPT, WR_ISSUE, DONE.
- IDLE:
  - mem_write=1 -> WR_ISSUE.
  - Else mem_read=1 -> RD_ISSUE.
  - Both high: write wins; the read is dropped, not queued.
- RD_ISSUE: ram_read=1 for one cycle; RAM registers memory[MAR] at the ending edge. -> RD_WAIT.
- RD_WAIT: ram_read=0; ram_data_out is now valid. -> RD_CAPT.
- RD_CAPT: MDR <= ram_data_out at the ending edge. -> DONE.
- WR_ISSUE: ram_write=1 for exactly one cycle; data = MDR. -> DONE.
- DONE:
  - done=1 for one cycle; mdr_out already reflects read data.
  - -> IDLE.
  - A new request may be sampled in the cycle after DONE, not during it.
- Latency from request edge to done high:
  - Read: 4 cycles (RD_ISSUE, RD_WAIT, RD_CAPT, DONE).
  - Write: 2 cycles.
- busy=1 in every state except IDLE.
- mem_read/mem_write/mar_in/mdr_in asserted while busy are ignored; no side effects.
- Reset mid-operation: immediate return to IDLE with all outputs cleared.
  - An in-flight write whose WR_ISSUE edge has not occurred is not performed.
  - No done pulse is issued.
- Never assert ram_read and ram_write together.

Optional Feature:
- Macro MEM_ADDR_CHECK_EN.
- Defined:
  - At request acceptance, if MAR[DATA_W-1:ADDR_W] != 0: skip all RAM strobes and go directly to DONE.
  - MDR is unchanged.
  - addr_err=1 together with done, held until the next accepted request or reset.
- Undefined:
  - Upper MAR bits are silently ignored (address wraps modulo 512).
  - addr_err is tied 0.

Test Plan:
- Reset: hold clear=0 mid-read (in RD_WAIT) -> state IDLE, done never pulses, MDR=0, ram_read=0 immediately.
- Read: RAM preloaded with memory[0x95]=0x000000FF; bus_in=0x95, mar_in=1, mem_read=1 -> ram_read high 1 cycle, done 4 cycles later, mdr_out=0x000000FF.
- Write then read-back:
  - MAR=0x1F0, MDR=0xDEADBEEF, mem_write=1 -> ram_write for exactly 1 cycle, done after 2 cycles.
  - Read of 0x1F0 -> mdr_out=0xDEADBEEF.
- Simultaneous/busy requests:
  - mem_read=mem_write=1 in IDLE -> write only.
  - mdr_in=1 with bus_in=0x12345678 during RD_WAIT -> MDR unchanged until capture.
- Back-to-back: mem_read held high continuously -> new request accepted every 5 cycles; ram_read and ram_write never both high.
- Optional (MEM_ADDR_CHECK_EN): MAR=0x00000200, mem_read -> no ram_read, done at the next cycle, addr_err=1, MDR unchanged. Without the macro: RAM address 0x000 is read.
